unidad_busqueda: RTL and testbench
==================================

// Module: unidad_busqueda
// PURPOSE
//  Instruction-fetch front end of the single-cycle processor; sits directly upstream of the
//  instruction memory. Holds the program counter (PC) and drives the memory word address.
//  Returns the fetched word to decode and selects the next PC: sequential, branch or jump.
//  Also provides stall, halt detection and a retired-instruction counter.
// PARAMETERS
//  ADDR_W     6             word-address width (instruction memory depth = 2**ADDR_W)
//  DATA_W     32            instruction width
//  RESET_PC   0             PC value loaded on reset
//  HALT_WORD  32'hFFFF_FFFF instruction encoding that halts fetch
//  CNT_W      16            width of retired-instruction counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  stall        in   1       1 = hold PC and counter this cycle
//  branch_taken in   1       1 = take PC-relative branch
//  branch_off   in   ADDR_W  signed word offset, relative to PC+1
//  jump         in   1       1 = absolute jump
//  jump_target  in   ADDR_W  absolute word address for jump
//  direinstru   out  ADDR_W  word address to instruction memory (= PC)
//  instru       in   DATA_W  word returned by instruction memory (combinational)
//  instr_out    out  DATA_W  instruction to decode; 0 when valid=0
//  pc_plus1     out  ADDR_W  PC+1 mod 2**ADDR_W, for link/branch use in decode
//  valid        out  1       instr_out is a real instruction this cycle
//  halted       out  1       fetch stopped on HALT_WORD
//  retired      out  CNT_W   count of PC advances since reset, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): PC=RESET_PC, state=BOOT, retired=0, valid=0, halted=0,
//    instr_out=0. direinstru=RESET_PC immediately.
//  - FSM states: BOOT, RUN, HALT.
//    BOOT -> RUN on the first rising edge after rst_n goes high; PC does not move.
//    RUN  -> HALT on an edge where instru==HALT_WORD, regardless of stall; PC holds.
//    HALT -> HALT; only rst_n exits it.
//  - Outputs from state: valid = (state==RUN); halted = (state==HALT).
//    instr_out = valid ? instru : 0. pc_plus1 is combinational from PC in every state.
//  - PC update, only in RUN, on an edge with stall=0 and instru!=HALT_WORD:
//    priority jump > branch_taken > sequential.
//      jump:   PC <= jump_target
//      branch: PC <= PC + 1 + sign_ext(branch_off), truncated to ADDR_W (mod 2**ADDR_W)
//      else:   PC <= PC + 1, wraps 2**ADDR_W-1 -> 0
//  - stall=1 in RUN: PC, retired and state hold; jump/branch inputs are ignored
//    (not latched). Decode must re-present them when stall is released.
//  - retired increments by 1 on every PC update and saturates at 2**CNT_W-1.
//  - Latency: a new PC appears on direinstru in the cycle after the edge that selects it.
//    Memory read is zero-cycle, so instr_out is valid in the same cycle.
//  - jump/branch/stall in BOOT or HALT: no effect.
//  - rst_n asserted mid-operation: all state returns to reset values immediately,
//    without waiting for a clock edge.
// STRUCTURE
//  - Shared processor package: ADDR_W/DATA_W defaults, HALT_WORD, FSM state encoding
//    (BOOT=2'd0, RUN=2'd1, HALT=2'd2).
//  - Sub-module: calc_siguiente_pc (combinational next-PC mux/adder: PC, branch_off,
//    jump_target, select bits -> next PC). FSM, PC register and counter stay at top level.
// TESTING (bench instantiates this block + instruction memory; clk period 10 ns)
//  1. Hold rst_n=0 -> direinstru=0, valid=0, retired=0; release, 1 edge -> valid=1,
//     direinstru=0.
//  2. Free run 3 edges after BOOT -> direinstru 0->1->2->3, retired=3, instr_out == mem[PC].
//  3. At PC=5: branch_taken=1, branch_off=-2 -> next PC=4. Same cycle with jump=1,
//     jump_target=9 -> PC=9 (jump wins).
//  4. jump_target=6'h3F -> PC=63. Next sequential edge -> PC=0 (wrap); retired still
//     increments.
//  5. stall=1 for 3 edges with jump=1 -> PC and retired unchanged; stall=0 -> jump taken.
//  6. Memory word = 32'hFFFF_FFFF at PC=2 -> halted=1, valid=0, PC stuck at 2.
//     Pulse rst_n low mid-cycle -> PC=0 before the next edge; BOOT->RUN resumes.

Source files
------------

// File: rtl/unidad_busqueda_pkg.sv
// Shared processor definitions for the fetch front end.
package unidad_busqueda_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } estado_t;

endpackage

// File: rtl/unidad_busqueda_calc_siguiente_pc.sv
// Combinational next-PC selection: jump > branch > sequential.
module calc_siguiente_pc
    import unidad_busqueda_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              jump,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [ADDR_W-1:0] pc_next
);

    // Adding the ADDR_W-bit offset modulo 2**ADDR_W equals adding its sign extension.
    always_comb begin
        pc_plus1 = pc + ADDR_W'(1);
        pc_next  = pc_plus1;
        if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = pc_plus1 + branch_off;
        end
    end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction-fetch front end: PC register, BOOT/RUN/HALT control and retired counter.
module unidad_busqueda
    import unidad_busqueda_pkg::*;
#(
    parameter int unsigned        ADDR_W    = ADDR_W_DEF,
    parameter int unsigned        DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(HALT_WORD_DEF),
    parameter int unsigned        CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] direinstru,
    input  logic [DATA_W-1:0] instru,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    estado_t           state, next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W-1:0]  retired_q;
    logic              advance;

    calc_siguiente_pc #(
        .ADDR_W(ADDR_W)
    ) u_calc (
        .pc          (pc),
        .branch_off  (branch_off),
        .jump_target (jump_target),
        .jump        (jump),
        .branch_taken(branch_taken),
        .pc_plus1    (pc_plus1),
        .pc_next     (pc_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next state and PC-advance decision; halt word wins over stall.
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        case (state)
            BOOT: next_state = RUN;
            RUN: begin
                if (instru == HALT_WORD) begin
                    next_state = HALT;
                end else if (!stall) begin
                    advance = 1'b1;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = BOOT;
        endcase
    end

    // PC register and saturating retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            retired_q <= '0;
        end else if (advance) begin
            pc <= pc_next;
            if (retired_q != '1) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Output decode.
    always_comb begin
        valid      = (state == RUN);
        halted     = (state == HALT);
        instr_out  = valid ? instru : '0;
        direinstru = pc;
        retired    = retired_q;
    end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for unidad_busqueda with a combinational instruction memory.
module tb_unidad_busqueda;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [5:0]  branch_off = '0;
    logic        jump = 1'b0;
    logic [5:0]  jump_target = '0;
    logic [5:0]  direinstru, pc_plus1, direinstru_s, pc_plus1_s;
    logic [31:0] instru, instr_out, instru_s, instr_out_s;
    logic        valid, halted, valid_s, halted_s;
    logic [15:0] retired;
    logic [2:0]  retired_s;
    logic [31:0] mem [64];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign instru   = mem[direinstru];
    assign instru_s = mem[direinstru_s];

    unidad_busqueda dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_off(branch_off), .jump(jump), .jump_target(jump_target),
        .direinstru(direinstru), .instru(instru), .instr_out(instr_out),
        .pc_plus1(pc_plus1), .valid(valid), .halted(halted), .retired(retired)
    );

    // Narrow-counter instance to reach saturation quickly.
    unidad_busqueda #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_off(branch_off), .jump(jump), .jump_target(jump_target),
        .direinstru(direinstru_s), .instru(instru_s), .instr_out(instr_out_s),
        .pc_plus1(pc_plus1_s), .valid(valid_s), .halted(halted_s), .retired(retired_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (direinstru !== 6'd0) begin bad++; $display("FAIL rst_pc got=%0d exp=0", direinstru); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL rst_retired got=%0d exp=0", retired); end
        total++; if (instr_out !== 32'd0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_out); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
        rst_n = 1'b1;
        step();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL boot_valid got=%b exp=1", valid); end
        total++; if (direinstru !== 6'd0) begin bad++; $display("FAIL boot_pc got=%0d exp=0", direinstru); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL boot_retired got=%0d exp=0", retired); end
        total++; if (instr_out !== 32'h1000_0000) begin bad++; $display("FAIL boot_instr got=%h exp=10000000", instr_out); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_w;
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_w = 32'h1000_0000 + 32'(k);
            total++; if (direinstru !== 6'(k)) begin bad++; $display("FAIL run_pc got=%0d exp=%0d", direinstru, k); end
            total++; if (retired !== 16'(k)) begin bad++; $display("FAIL run_retired got=%0d exp=%0d", retired, k); end
            total++; if (instr_out !== exp_w) begin bad++; $display("FAIL run_instr got=%h exp=%h", instr_out, exp_w); end
            total++; if (pc_plus1 !== 6'(k + 1)) begin bad++; $display("FAIL run_plus1 got=%0d exp=%0d", pc_plus1, k + 1); end
        end
    endtask

    task automatic test_branch_jump();
        repeat (2) step();
        total++; if (direinstru !== 6'd5) begin bad++; $display("FAIL br_setup got=%0d exp=5", direinstru); end
        branch_taken = 1'b1; branch_off = 6'h3E;  // -2
        step();
        total++; if (direinstru !== 6'd4) begin bad++; $display("FAIL branch_back got=%0d exp=4", direinstru); end
        total++; if (retired !== 16'd6) begin bad++; $display("FAIL branch_retired got=%0d exp=6", retired); end
        jump = 1'b1; jump_target = 6'd9;
        step();
        total++; if (direinstru !== 6'd9) begin bad++; $display("FAIL jump_prio got=%0d exp=9", direinstru); end
        jump = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 6'h3F;
        step();
        jump = 1'b0;
        total++; if (direinstru !== 6'd63) begin bad++; $display("FAIL jump_top got=%0d exp=63", direinstru); end
        total++; if (pc_plus1 !== 6'd0) begin bad++; $display("FAIL plus1_wrap got=%0d exp=0", pc_plus1); end
        step();
        total++; if (direinstru !== 6'd0) begin bad++; $display("FAIL pc_wrap got=%0d exp=0", direinstru); end
        total++; if (retired !== 16'd9) begin bad++; $display("FAIL wrap_retired got=%0d exp=9", retired); end
        total++; if (retired_s !== 3'd7) begin bad++; $display("FAIL sat_retired got=%0d exp=7", retired_s); end
    endtask

    task automatic test_stall();
        stall = 1'b1; jump = 1'b1; jump_target = 6'd20;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (direinstru !== 6'd0) begin bad++; $display("FAIL stall_pc got=%0d exp=0", direinstru); end
            total++; if (retired !== 16'd9) begin bad++; $display("FAIL stall_retired got=%0d exp=9", retired); end
        end
        stall = 1'b0;
        step();
        jump = 1'b0;
        total++; if (direinstru !== 6'd20) begin bad++; $display("FAIL unstall_pc got=%0d exp=20", direinstru); end
        total++; if (retired !== 16'd10) begin bad++; $display("FAIL unstall_retired got=%0d exp=10", retired); end
        total++; if (instr_out !== 32'h1000_0014) begin bad++; $display("FAIL unstall_instr got=%h exp=10000014", instr_out); end
    endtask

    task automatic test_halt();
        mem[2] = 32'hFFFF_FFFF;
        jump = 1'b1; jump_target = 6'd1;
        step();
        jump = 1'b0;
        step();
        total++; if (direinstru !== 6'd2) begin bad++; $display("FAIL halt_reach got=%0d exp=2", direinstru); end
        step();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted got=%b exp=1", halted); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b exp=0", valid); end
        total++; if (instr_out !== 32'd0) begin bad++; $display("FAIL halt_instr got=%h exp=0", instr_out); end
        total++; if (retired !== 16'd12) begin bad++; $display("FAIL halt_retired got=%0d exp=12", retired); end
        jump = 1'b1; jump_target = 6'd30;
        step();
        jump = 1'b0;
        total++; if (direinstru !== 6'd2) begin bad++; $display("FAIL halt_stuck got=%0d exp=2", direinstru); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (direinstru !== 6'd0) begin bad++; $display("FAIL async_pc got=%0d exp=0", direinstru); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL async_halted got=%b exp=0", halted); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL async_retired got=%0d exp=0", retired); end
        #1 rst_n = 1'b1;
        step();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL reboot_valid got=%b exp=1", valid); end
        total++; if (direinstru !== 6'd0) begin bad++; $display("FAIL reboot_pc got=%0d exp=0", direinstru); end
        step();
        total++; if (direinstru !== 6'd1) begin bad++; $display("FAIL reboot_run got=%0d exp=1", direinstru); end
        total++; if (retired !== 16'd1) begin bad++; $display("FAIL reboot_retired got=%0d exp=1", retired); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_free_run();
        test_branch_jump();
        test_wrap();
        test_stall();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
